// File: rtl/ahb_mem_slv.sv
// rtl/ahb_mem_slv.sv - AHB-Lite word-organised memory slave with configurable wait states
// Define AHB_MEM_SLV_ERR_EN to return two-cycle ERROR for out-of-range or misaligned transfers.
module ahb_mem_slv #(
  parameter int mem_d  = 256,
  parameter int wait_c = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [1:0]  htrans,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic [1:0]  hresp
);
  localparam int AW = $clog2(mem_d);
  localparam logic [2:0] WAIT_LD = (wait_c > 0) ? 3'(wait_c - 1) : 3'd0;

`ifdef AHB_MEM_SLV_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA} state_e;
`endif

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [3:0]    be_q, be_d;
  logic          wr_q, wr_d;
  logic [31:0]   mem_q [mem_d];

  logic          accept;
  logic          take;
  logic [3:0]    be_new;
  logic          unused_ok;

  assign accept    = hsel && htrans[1] && hready;
  assign unused_ok = ^{hburst, htrans[0], haddr};

  // Lane enables; low address bits beyond the transfer size are ignored.
  always_comb begin
    case (hsize)
      3'd0:    be_new = 4'b0001 << haddr[1:0];
      3'd1:    be_new = haddr[1] ? 4'b1100 : 4'b0011;
      default: be_new = 4'b1111;
    endcase
  end

`ifdef AHB_MEM_SLV_ERR_EN
  logic bad;
  logic hresp_err;

  always_comb begin
    bad = ({2'b00, haddr[31:2]} >= 32'(mem_d)) || (hsize > 3'd2) ||
          ((hsize == 3'd1) && haddr[0]) ||
          ((hsize == 3'd2) && (haddr[1:0] != 2'b00));
  end

  assign hresp = {1'b0, hresp_err};
`else
  assign hresp = 2'b00;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    be_d      = be_q;
    wr_d      = wr_q;
    hreadyout = 1'b1;
    take      = 1'b0;
`ifdef AHB_MEM_SLV_ERR_EN
    hresp_err = 1'b0;
`endif
    case (state_q)
      S_WAIT: begin
        hreadyout = 1'b0;
        if (cnt_q == 3'd0) state_d = S_DATA;
        else               cnt_d   = cnt_q - 3'd1;
      end
      S_DATA: begin
        take    = 1'b1;
        state_d = S_IDLE;
      end
`ifdef AHB_MEM_SLV_ERR_EN
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp_err = 1'b1;
        state_d   = S_ERR2;
      end
      S_ERR2: begin
        hresp_err = 1'b1;
        take      = 1'b1;
        state_d   = S_IDLE;
      end
`endif
      default: take = 1'b1;
    endcase

    // A new address phase overrides the default return to IDLE.
    if (take && accept) begin
      idx_d = haddr[AW+1:2];
      be_d  = be_new;
      wr_d  = hwrite;
      if (wait_c > 0) begin
        state_d = S_WAIT;
        cnt_d   = WAIT_LD;
      end else begin
        state_d = S_DATA;
      end
`ifdef AHB_MEM_SLV_ERR_EN
      if (bad) begin
        state_d = S_ERR1;
        cnt_d   = 3'd0;
      end
`endif
    end
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  // Storage is deliberately not reset; a reset edge during DATA drops the write.
  always_ff @(posedge hclk) begin
    if (!hreset && (state_q == S_DATA) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = ((state_q == S_DATA) && !wr_q) ? mem_q[idx_q] : 32'd0;

endmodule

// File: doc/ahb_mem_slv.md
AHB_MEM_SLV -- requirements
Module: ahb_mem_slv

Interface
REQ-001 The block SHALL have parameter mem_d, default 256, giving the storage depth in 32-bit words (power of two).
REQ-002 The block SHALL have parameter wait_c, default 0, giving the data-phase wait states per accepted OKAY transfer (0..7).
REQ-003 The block SHALL have one clock and a synchronous active-high reset; all state SHALL change only on the rising edge of hclk.
REQ-004 Port hclk, input, 1: AHB clock.
REQ-005 Port hreset, input, 1: synchronous active-high reset.
REQ-006 Port hsel, input, 1: slave select from the address decoder.
REQ-007 Port haddr, input, 32: address-phase address.
REQ-008 Port hwrite, input, 1: address-phase write flag.
REQ-009 Port htrans, input, 2: transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
REQ-010 Port hsize, input, 3: transfer size (0 byte, 1 half, 2 word).
REQ-011 Port hburst, input, 3: burst type; accepted and ignored.
REQ-012 Port hwdata, input, 32: data-phase write data.
REQ-013 Port hready, input, 1: bus-level ready, gating address-phase acceptance.
REQ-014 Port hrdata, output, 32: read data.
REQ-015 Port hreadyout, output, 1: slave ready.
REQ-016 Port hresp, output, 2: response (0 OKAY, 1 ERROR).

Function
REQ-017 A transfer SHALL be accepted on a rising edge where hsel=1, htrans[1]=1 and hready=1; haddr, hwrite and hsize SHALL be captured on that edge.
REQ-018 IDLE/BUSY or unselected cycles SHALL produce a zero-wait OKAY (hreadyout=1, hresp=0) and no storage access.
REQ-019 The state machine SHALL use states IDLE, WAIT, DATA, ERR1 and ERR2.
REQ-020 From IDLE or DATA, an accepted OKAY transfer SHALL go to WAIT if wait_c>0, otherwise to DATA.
REQ-021 WAIT SHALL hold hreadyout=0 for exactly wait_c cycles, using a counter loaded with wait_c-1, then go to DATA.
REQ-022 DATA SHALL drive hreadyout=1 and hresp=0, and SHALL accept a new transfer on the same edge (pipelined back-to-back).
REQ-023 A DATA-phase write SHALL commit on the edge ending DATA, updating only the lanes selected by hsize and haddr[1:0] (byte lane haddr[1:0], half lane haddr[1], word all lanes).
REQ-024 A read SHALL drive hrdata with the full 32-bit stored word at haddr[log2(mem_d)+1:2] while in DATA; otherwise hrdata SHALL be 0.
REQ-025 A read whose data phase immediately follows a write to the same word SHALL return the newly written data.
REQ-026 An accepted transfer SHALL be an error if any of the following holds: haddr[31:2] >= mem_d; halfword with haddr[0]=1; word with haddr[1:0]!=0; hsize>2.
REQ-027 An error transfer SHALL enter ERR1 (hreadyout=0, hresp=1), then ERR2 (hreadyout=1, hresp=1), then IDLE, with no storage update.
REQ-028 Transfers presented during ERR1 SHALL be ignored.
REQ-029 A transfer presented during ERR2 with hready=1 SHALL be accepted normally.

Reset
REQ-030 With hreset=1, the block SHALL go to state IDLE with hreadyout=1, hresp=0, hrdata=0 and the wait counter at 0.
REQ-031 A reset asserted in WAIT, DATA, ERR1 or ERR2 SHALL abort the transfer with no storage write.
REQ-032 Storage contents SHALL NOT be cleared by reset.

Configuration
REQ-033 With macro AHB_MEM_SLV_ERR_EN defined, error detection SHALL follow REQ-026 to REQ-029.
REQ-034 Without AHB_MEM_SLV_ERR_EN, hresp SHALL be tied to 0 and states ERR1/ERR2 SHALL be absent.
REQ-035 Without AHB_MEM_SLV_ERR_EN, out-of-range addresses SHALL wrap modulo mem_d.
REQ-036 Without AHB_MEM_SLV_ERR_EN, misaligned low address bits SHALL be ignored and hsize>2 SHALL be treated as word.

Verification
REQ-037 With wait_c=0: write 0xDEADBEEF to 0x10, then read 0x10 back-to-back -> hreadyout never 0, hrdata=0xDEADBEEF, hresp=0.
REQ-038 With wait_c=3: single read -> exactly 3 cycles with hreadyout=0, then DATA with correct hrdata.
REQ-039 Word 0x0 = 0x11223344; byte write 0xAA to 0x2, then half write 0x5566 at 0x0 -> read returns 0x11AA5566.
REQ-040 With ERR_EN: word read at 0x3, then write to 0x400 (mem_d=256) -> each gives two-cycle ERROR (hresp=1 with hreadyout=0, then hresp=1 with hreadyout=1); storage unchanged.
REQ-041 Reset asserted during WAIT of a write to 0x20 -> hreadyout=1 next cycle and word 0x20 retains its old value.
REQ-042 Without ERR_EN: write 0x12345678 to 0x404 -> read 0x004 returns 0x12345678 and hresp=0.
